// File: rtl/vx_smem_responder_pkg.sv
// Shared types and sizing for the shared-memory responder and its banks.
package vx_smem_responder_pkg;

    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned NUM_BANKS   = 4;
    localparam int unsigned BANK_WORDS  = 256;
    localparam int unsigned TAGW        = 8;
    localparam int unsigned WORDW       = 32;
    localparam int unsigned ADDRW       = 30;
    localparam int unsigned BYTEENW     = WORDW / 8;
    localparam int unsigned BANK_BITS   = $clog2(NUM_BANKS);
    localparam int unsigned ROW_BITS    = $clog2(BANK_WORDS);
    localparam int unsigned LANE_BITS   = $clog2(NUM_THREADS);

    typedef struct packed {
        logic               rw;
        logic [ADDRW-1:0]   addr;
        logic [BYTEENW-1:0] byteen;
        logic [WORDW-1:0]   data;
        logic [TAGW-1:0]    tag;
    } smem_req_t;

    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [TAGW-1:0]        tag;
    } smem_rsp_t;

    function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDRW-1:0] addr);
        return addr[BANK_BITS-1:0];
    endfunction

    function automatic logic [ROW_BITS-1:0] row_of(input logic [ADDRW-1:0] addr);
        return addr[BANK_BITS +: ROW_BITS];
    endfunction

endpackage

// File: rtl/vx_smem_responder_bank.sv
// One word-wide scratchpad bank: byte-enabled write, read-enabled registered read.
module vx_smem_responder_bank
    import vx_smem_responder_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [ROW_BITS-1:0] i_row,
    input  logic [BYTEENW-1:0]  i_byteen,
    input  logic [WORDW-1:0]    i_wdata,
    output logic [WORDW-1:0]    o_rdata
);

    logic [WORDW-1:0] r_mem [BANK_WORDS];
    logic [WORDW-1:0] r_rdata;

    // RAM array and read register are intentionally not reset; read data holds while i_re is low.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < int'(BYTEENW); k++) begin
                if (i_byteen[k]) begin
                    r_mem[i_row][k*8 +: 8] <= i_wdata[k*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_row];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vx_smem_responder.sv
// Shared-memory responder: per-bank lane arbitration with load broadcast, merged one-cycle load response.
module vx_smem_responder
    import vx_smem_responder_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_THREADS-1:0]         i_req_valid,
    input  logic [NUM_THREADS-1:0]         i_req_rw,
    input  logic [NUM_THREADS*ADDRW-1:0]   i_req_addr,
    input  logic [NUM_THREADS*BYTEENW-1:0] i_req_byteen,
    input  logic [NUM_THREADS*WORDW-1:0]   i_req_data,
    input  logic [NUM_THREADS*TAGW-1:0]    i_req_tag,
    output logic [NUM_THREADS-1:0]         o_req_ready,
    output logic                           o_rsp_valid,
    output logic [NUM_THREADS-1:0]         o_rsp_tmask,
    output logic [NUM_THREADS*WORDW-1:0]   o_rsp_data,
    output logic [TAGW-1:0]                o_rsp_tag,
    input  logic                           i_rsp_ready
);

    smem_req_t              w_req       [NUM_THREADS];
    logic [BANK_BITS-1:0]   w_lane_bank [NUM_THREADS];
    logic [ROW_BITS-1:0]    w_lane_row  [NUM_THREADS];
    logic                   w_stall;
    logic [NUM_THREADS-1:0] w_grant;
    logic [NUM_THREADS-1:0] w_ld_grant;
    logic [TAGW-1:0]        w_rsp_tag;
    logic [NUM_BANKS-1:0]   w_found;
    logic [NUM_BANKS-1:0]   w_we;
    logic [NUM_BANKS-1:0]   w_re;
    logic [LANE_BITS-1:0]   w_win       [NUM_BANKS];
    logic [ROW_BITS-1:0]    w_bank_row  [NUM_BANKS];
    logic [BYTEENW-1:0]     w_bank_be   [NUM_BANKS];
    logic [WORDW-1:0]       w_bank_wdata[NUM_BANKS];
    logic [WORDW-1:0]       w_bank_rdata[NUM_BANKS];

    smem_rsp_t              r_rsp;
    logic                   r_rsp_valid;
    logic [BANK_BITS-1:0]   r_lane_bank [NUM_THREADS];

    always_comb begin
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            w_req[i].rw     = i_req_rw[i];
            w_req[i].addr   = i_req_addr[i*ADDRW +: ADDRW];
            w_req[i].byteen = i_req_byteen[i*BYTEENW +: BYTEENW];
            w_req[i].data   = i_req_data[i*WORDW +: WORDW];
            w_req[i].tag    = i_req_tag[i*TAGW +: TAGW];
            w_lane_bank[i]  = bank_of(w_req[i].addr);
            w_lane_row[i]   = row_of(w_req[i].addr);
        end
    end

    assign w_stall = r_rsp_valid & ~i_rsp_ready;

    // Lowest valid lane wins each bank; a winning load also grants same-row loads in that bank.
    always_comb begin
        w_found = '0;
        w_we    = '0;
        w_re    = '0;
        w_grant = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            w_win[b]        = '0;
            w_bank_row[b]   = '0;
            w_bank_be[b]    = '0;
            w_bank_wdata[b] = '0;
        end
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                if (!w_found[b] && i_req_valid[i] && (w_lane_bank[i] == BANK_BITS'(b))) begin
                    w_found[b] = 1'b1;
                    w_win[b]   = LANE_BITS'(i);
                end
            end
            w_bank_row[b]   = w_lane_row[w_win[b]];
            w_bank_be[b]    = w_req[w_win[b]].byteen;
            w_bank_wdata[b] = w_req[w_win[b]].data;
            if (w_found[b] && !w_stall) begin
                if (w_req[w_win[b]].rw) begin
                    w_we[b]           = 1'b1;
                    w_grant[w_win[b]] = 1'b1;
                end else begin
                    w_re[b] = 1'b1;
                    for (int i = 0; i < int'(NUM_THREADS); i++) begin
                        if (i_req_valid[i] && !w_req[i].rw && (w_lane_bank[i] == BANK_BITS'(b))
                            && (w_lane_row[i] == w_bank_row[b])) begin
                            w_grant[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign w_ld_grant  = w_grant & ~i_req_rw;
    assign o_req_ready = w_grant;

    always_comb begin
        w_rsp_tag = '0;
        for (int i = int'(NUM_THREADS) - 1; i >= 0; i--) begin
            if (w_ld_grant[i]) begin
                w_rsp_tag = w_req[i].tag;
            end
        end
    end

    // Response register is frozen while the consumer back-pressures.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_lane_bank[i] <= '0;
            end
        end else if (!w_stall) begin
            r_rsp_valid <= |w_ld_grant;
            r_rsp.tmask <= w_ld_grant;
            r_rsp.tag   <= w_rsp_tag;
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                r_lane_bank[i] <= w_lane_bank[i];
            end
        end
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        vx_smem_responder_bank u_bank (
            .i_clk    (i_clk),
            .i_we     (w_we[b]),
            .i_re     (w_re[b]),
            .i_row    (w_bank_row[b]),
            .i_byteen (w_bank_be[b]),
            .i_wdata  (w_bank_wdata[b]),
            .o_rdata  (w_bank_rdata[b])
        );
    end

    always_comb begin
        o_rsp_data = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            o_rsp_data[i*WORDW +: WORDW] = w_bank_rdata[r_lane_bank[i]];
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_tmask = r_rsp.tmask;
    assign o_rsp_tag   = r_rsp.tag;

`ifndef SYNTHESIS
    logic [NUM_THREADS-1:0] r_pend;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                assert (!(r_pend[i] && !i_req_valid[i]))
                    else $error("lane %0d request withdrawn before grant", i);
                if (w_ld_grant[i]) begin
                    assert (w_req[i].tag == w_rsp_tag)
                        else $error("lane %0d load tag differs from merged tag", i);
                end
            end
            r_pend <= i_req_valid & ~w_grant;
        end
    end
`endif

endmodule

// File: tb/tb_vx_smem_responder.sv
// Directed bench for vx_smem_responder with hand-computed expectations.
module tb_vx_smem_responder;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_rw;
    logic [119:0] req_addr;
    logic [15:0]  req_byteen;
    logic [127:0] req_data;
    logic [31:0]  req_tag;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [3:0]   rsp_tmask;
    logic [127:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic         rsp_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp2 [4] = '{32'h10, 32'h20, 32'h21, 32'h22};

    vx_smem_responder dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .i_req_rw     (req_rw),
        .i_req_addr   (req_addr),
        .i_req_byteen (req_byteen),
        .i_req_data   (req_data),
        .i_req_tag    (req_tag),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_tmask  (rsp_tmask),
        .o_rsp_data   (rsp_data),
        .o_rsp_tag    (rsp_tag),
        .i_rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic clear_req();
        req_valid  = '0;
        req_rw     = '0;
        req_addr   = '0;
        req_byteen = '0;
        req_data   = '0;
        req_tag    = '0;
    endtask

    task automatic set_load(input int i, input logic [29:0] a, input logic [7:0] t);
        req_valid[i]         = 1'b1;
        req_rw[i]            = 1'b0;
        req_addr[i*30 +: 30] = a;
        req_tag[i*8 +: 8]    = t;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single lane-0 store; checks it is granted alone and produces no response.
    task automatic store1(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        clear_req();
        req_valid[0]     = 1'b1;
        req_rw[0]        = 1'b1;
        req_addr[29:0]   = a;
        req_byteen[3:0]  = be;
        req_data[31:0]   = d;
        #2;
        chk("store_ready", 128'(req_ready), 128'h1);
        next_cycle();
        clear_req();
        chk("store_no_rsp", 128'(rsp_valid), 128'h0);
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        clear_req();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 128'(rsp_valid), 128'h0);
        chk("reset_tmask", 128'(rsp_tmask), 128'h0);
        rst = 1'b0;

        // Preload
        store1(30'd0,  32'h10, 4'hF);
        store1(30'd1,  32'h11, 4'hF);
        store1(30'd2,  32'h12, 4'hF);
        store1(30'd3,  32'h13, 4'hF);
        store1(30'd4,  32'h20, 4'hF);
        store1(30'd8,  32'h21, 4'hF);
        store1(30'd12, 32'h22, 4'hF);
        store1(30'd5,  32'h55, 4'hF);

        // 1: four lanes, four banks, one cycle
        for (int i = 0; i < 4; i++) set_load(i, 30'(i), 8'h5A);
        #2;
        chk("t1_ready", 128'(req_ready), 128'hF);
        next_cycle();
        clear_req();
        chk("t1_valid", 128'(rsp_valid), 128'h1);
        chk("t1_tmask", 128'(rsp_tmask), 128'hF);
        chk("t1_data",  rsp_data, 128'h00000013_00000012_00000011_00000010);
        chk("t1_tag",   128'(rsp_tag), 128'h5A);
        next_cycle();
        chk("t1_idle", 128'(rsp_valid), 128'h0);

        // 2: all lanes on bank 0, distinct rows -> serialised
        for (int i = 0; i < 4; i++) set_load(i, 30'(4 * i), 8'h33);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("t2_ready", 128'(req_ready), 128'(4'b0001 << k));
            next_cycle();
            req_valid[k] = 1'b0;
            chk("t2_valid", 128'(rsp_valid), 128'h1);
            chk("t2_tmask", 128'(rsp_tmask), 128'(4'b0001 << k));
            chk("t2_data",  128'(rsp_data[k*32 +: 32]), 128'(exp2[k]));
            chk("t2_tag",   128'(rsp_tag), 128'h33);
        end
        clear_req();

        // 3: broadcast of one address to all lanes
        for (int i = 0; i < 4; i++) set_load(i, 30'd5, 8'h44);
        #2;
        chk("t3_ready", 128'(req_ready), 128'hF);
        next_cycle();
        clear_req();
        chk("t3_tmask", 128'(rsp_tmask), 128'hF);
        chk("t3_data",  rsp_data, {4{32'h00000055}});

        // 4: byte-enabled store merges into existing word
        store1(30'd2, 32'hFFFFFFFF, 4'hF);
        store1(30'd2, 32'h00AB0000, 4'b0100);
        set_load(0, 30'd2, 8'h01);
        #2;
        chk("t4_ready", 128'(req_ready), 128'h1);
        next_cycle();
        clear_req();
        chk("t4_tmask", 128'(rsp_tmask), 128'h1);
        chk("t4_data",  128'(rsp_data[31:0]), 128'hFFABFFFF);

        // 5: back-pressure freezes grants and response
        set_load(0, 30'd1, 8'h77);
        next_cycle();
        clear_req();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_load(i, 30'(i), 8'h66);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("t5_stall_ready", 128'(req_ready), 128'h0);
            next_cycle();
            chk("t5_hold_valid", 128'(rsp_valid), 128'h1);
            chk("t5_hold_tmask", 128'(rsp_tmask), 128'h1);
            chk("t5_hold_data",  128'(rsp_data[31:0]), 128'h11);
            chk("t5_hold_tag",   128'(rsp_tag), 128'h77);
        end
        rsp_ready = 1'b1;
        #2;
        chk("t5_release_ready", 128'(req_ready), 128'hF);
        next_cycle();
        clear_req();
        chk("t5_new_tmask", 128'(rsp_tmask), 128'hF);
        chk("t5_new_tag",   128'(rsp_tag), 128'h66);
        chk("t5_new_data",  rsp_data, 128'h00000013_FFABFFFF_00000011_00000010);

        // 6: asynchronous reset while a response is pending
        set_load(0, 30'd3, 8'h09);
        next_cycle();
        clear_req();
        chk("t6_pre_valid", 128'(rsp_valid), 128'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 128'(rsp_valid), 128'h0);
        chk("t6_async_tmask", 128'(rsp_tmask), 128'h0);
        #1;
        rst = 1'b0;
        next_cycle();
        chk("t6_post_idle1", 128'(rsp_valid), 128'h0);
        next_cycle();
        chk("t6_post_idle2", 128'(rsp_valid), 128'h0);
        set_load(0, 30'd3, 8'h0A);
        #2;
        chk("t6_ready", 128'(req_ready), 128'h1);
        next_cycle();
        clear_req();
        chk("t6_valid", 128'(rsp_valid), 128'h1);
        chk("t6_data",  128'(rsp_data[31:0]), 128'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
